mac_dot_acc_stream: RTL

Multi-lane, streaming successor to the single-lane parallel MAC. Each accepted beat carries NUM_LANE activation/weight pairs. Their products are summed and accumulated over a programmable number of beats. The result is then rounded, shifted, saturated and presented through a valid/ready output. It sits between the operand buffers and the output writeback in a PE column. Unsigned activation mode supports post-ReLU data.

---
 rtl/mac_pkg.sv | 50 +++++
 rtl/mac_lane_tree.sv | 44 ++++
 rtl/mac_dot_acc_stream.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC family: FSM states, beat tags, product
// width helper and the signed saturation function.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_state_e;

  // Sideband travelling with each beat through the P and A stages
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

  // Widest value the shared saturation function can clamp
  localparam int unsigned SAT_MAX_W = 64;

  // Width of the lane-product sum: (DW+1)x(DW) product plus adder-tree growth
  function automatic int unsigned prod_width(input int unsigned data_w,
                                             input int unsigned num_lane);
    return 2 * data_w + 1 + $clog2(num_lane);
  endfunction

  // Clamp a signed value to a res_w-bit two's complement range
  function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
      input  logic signed [SAT_MAX_W-1:0] val,
      input  int unsigned                 res_w,
      output logic                        sat);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    logic signed [SAT_MAX_W-1:0] res;
    hi  = $signed((SAT_MAX_W'(1) << (res_w - 1)) - SAT_MAX_W'(1));
    lo  = ~hi;
    res = val;
    sat = 1'b0;
    if (val > hi) begin
      res = hi;
      sat = 1'b1;
    end else if (val < lo) begin
      res = lo;
      sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// Combinational multiply + adder tree for one beat.
// Ports:
//   act_i        packed activations, lane 0 in LSBs
//   w_i          packed signed weights, lane 0 in LSBs
//   act_signed_i 1: activations sign-extended, 0: zero-extended
//   psum_c       signed sum of all lane products (PROD_W bits)
module mac_lane_tree
  import mac_pkg::*;
#(
  parameter  int unsigned NUM_LANE   = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned PROD_W     = prod_width(DATA_WIDTH, NUM_LANE)
) (
  input  logic [NUM_LANE*DATA_WIDTH-1:0] act_i,
  input  logic [NUM_LANE*DATA_WIDTH-1:0] w_i,
  input  logic                           act_signed_i,
  output logic signed [PROD_W-1:0]       psum_c
);

  localparam int unsigned MUL_W = 2 * DATA_WIDTH + 1;

  logic signed [MUL_W-1:0] prod [NUM_LANE];

  // Per-lane (DW+1)-bit activation times DW-bit signed weight
  for (genvar g = 0; g < int'(NUM_LANE); g++) begin : g_lane
    logic [DATA_WIDTH-1:0]   a_raw;
    logic [DATA_WIDTH-1:0]   w_raw;
    logic signed [DATA_WIDTH:0] a_ext;

    assign a_raw   = act_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_raw   = w_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign a_ext   = $signed({act_signed_i & a_raw[DATA_WIDTH-1], a_raw});
    assign prod[g] = MUL_W'(a_ext) * MUL_W'($signed(w_raw));
  end

  // Adder tree, each product sign-extended to the sum width
  always_comb begin
    psum_c = '0;
    for (int i = 0; i < int'(NUM_LANE); i++) begin
      psum_c = psum_c + PROD_W'(prod[i]);
    end
  end

endmodule

// File: rtl/mac_dot_acc_stream.sv
// Streaming multi-lane dot-product accumulator with round/shift/saturate
// output through a valid/ready handshake.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_*, accum_prev     per-dot-product config, latched on the first beat
//   in_valid/in_ready     input beat handshake (act_in, w_in)
//   out_valid/out_ready   result handshake (result, result_sat)
//   busy                  high whenever the FSM is not IDLE
module mac_dot_acc_stream
  import mac_pkg::*;
#(
  parameter int unsigned NUM_LANE     = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned SHIFT_WIDTH  = $clog2(ACC_WIDTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CNT_WIDTH-1:0]           cfg_len,
  input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
  input  logic                           cfg_bias_en,
  input  logic                           cfg_act_signed,
  input  logic [ACC_WIDTH-1:0]           accum_prev,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANE*DATA_WIDTH-1:0] act_in,
  input  logic [NUM_LANE*DATA_WIDTH-1:0] w_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RESULT_WIDTH-1:0]        result,
  output logic                           result_sat,
  output logic                           busy
);

  localparam int unsigned PROD_W = prod_width(DATA_WIDTH, NUM_LANE);
  localparam int unsigned AW1    = ACC_WIDTH + 1;

  mac_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   bias_en_q, bias_en_d;
  logic                   act_signed_q, act_signed_d;
  logic [ACC_WIDTH-1:0]   bias_q, bias_d;

  beat_tag_t              p_tag_q, p_tag_d;
  beat_tag_t              a_tag_q, a_tag_d;
  logic signed [PROD_W-1:0]    psum_c, psum_q, psum_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  logic                    out_valid_q, out_valid_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic                    result_sat_q, result_sat_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;

  logic                    accept;
  logic                    act_signed_eff;
  logic [CNT_WIDTH-1:0]    len_eff;
  logic                    is_last;
  logic [RESULT_WIDTH-1:0] round_res;
  logic                    round_sat;

  assign accept = in_valid && in_ready_q;

  // First beat arrives while still IDLE, so it uses the live config port
  assign act_signed_eff = (state_q == IDLE) ? cfg_act_signed : act_signed_q;
  assign len_eff        = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;

  mac_lane_tree #(
    .NUM_LANE  (NUM_LANE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_tree (
    .act_i       (act_in),
    .w_i         (w_in),
    .act_signed_i(act_signed_eff),
    .psum_c      (psum_c)
  );

  // Round half up, arithmetic shift at ACC_WIDTH+1 bits, then saturate
  always_comb begin
    logic signed [AW1-1:0] acc_ext;
    logic signed [AW1-1:0] round_add;
    logic signed [AW1-1:0] shifted;
    round_sat = 1'b0;
    acc_ext   = AW1'(acc_q);
    round_add = '0;
    if (shift_q != '0) begin
      round_add = AW1'(1) <<< (shift_q - SHIFT_WIDTH'(1));
    end
    shifted   = (acc_ext + round_add) >>> shift_q;
    round_res = RESULT_WIDTH'(sat_signed(SAT_MAX_W'(shifted), RESULT_WIDTH, round_sat));
  end

  // Next-state, pipeline and output logic
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    shift_d      = shift_q;
    bias_en_d    = bias_en_q;
    act_signed_d = act_signed_q;
    bias_d       = bias_q;
    p_tag_d      = '0;
    psum_d       = psum_q;
    a_tag_d      = p_tag_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    result_sat_d = result_sat_q;
    is_last      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          len_d        = len_eff;
          shift_d      = cfg_shift;
          bias_en_d    = cfg_bias_en;
          act_signed_d = cfg_act_signed;
          bias_d       = accum_prev;
          beat_cnt_d   = CNT_WIDTH'(1);
          is_last      = (len_eff == CNT_WIDTH'(1));
          p_tag_d      = '{valid: 1'b1, first: 1'b1, last: is_last};
          psum_d       = psum_c;
          state_d      = is_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          is_last    = (beat_cnt_q == len_q - CNT_WIDTH'(1));
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          p_tag_d    = '{valid: 1'b1, first: 1'b0, last: is_last};
          psum_d     = psum_c;
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Output register loads on the same edge as this transition
        if (a_tag_q.valid && a_tag_q.last) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stage: restart from bias/zero on the first beat of a dot product
    if (p_tag_q.valid) begin
      if (p_tag_q.first) begin
        acc_d = (bias_en_q ? $signed(bias_q) : '0) + ACC_WIDTH'(psum_q);
      end else begin
        acc_d = acc_q + ACC_WIDTH'(psum_q);
      end
    end

    // O stage: load on the final beat, hold until consumed
    if (a_tag_q.valid && a_tag_q.last) begin
      out_valid_d  = 1'b1;
      result_d     = round_res;
      result_sat_d = round_sat;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      shift_q      <= '0;
      bias_en_q    <= 1'b0;
      act_signed_q <= 1'b0;
      bias_q       <= '0;
      p_tag_q      <= '0;
      psum_q       <= '0;
      a_tag_q      <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      result_sat_q <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      shift_q      <= shift_d;
      bias_en_q    <= bias_en_d;
      act_signed_q <= act_signed_d;
      bias_q       <= bias_d;
      p_tag_q      <= p_tag_d;
      psum_q       <= psum_d;
      a_tag_q      <= a_tag_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      result_sat_q <= result_sat_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign result_sat = result_sat_q;
  assign busy       = busy_q;

endmodule
